// File: rtl/knapsack_pkg.sv
// Shared types and constants for the knapsack board sequencer.
package knapsack_pkg;

    // Operator-facing sequencer states
    typedef enum logic [2:0] {
        S_N,
        S_CAP,
        S_WT,
        S_PR,
        S_RUN,
        S_SHOW,
        S_ERR
    } state_e;

    // Prompt glyphs shown in the two leftmost digits
    localparam logic [3:0] GLYPH_N = 4'hE;
    localparam logic [3:0] GLYPH_W = 4'hB;
    localparam logic [3:0] GLYPH_P = 4'hC;

    // Error codes shown as "E<code>"
    localparam logic [3:0] ERR_ZERO_N  = 4'd1;
    localparam logic [3:0] ERR_SOLVER  = 4'd3;
    localparam logic [3:0] ERR_TIMEOUT = 4'd4;

    localparam int unsigned MAX_N_DEFAULT = 8;

endpackage

// File: rtl/solver_watchdog.sv
// Cycle counter that flags a solver which never answers.
module solver_watchdog #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_count;

    // Count is 0 on the start cycle and while idle, so cycle k after start holds k-1
    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            r_count <= '0;
        end else if (!expired) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = enable && !clear && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/knapsack_seq.sv
// Operator entry sequencer, solver supervisor and display driver.
module knapsack_seq
    import knapsack_pkg::*;
#(
    parameter int unsigned MAX_N   = MAX_N_DEFAULT,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        conf_pulse,
    input  logic        back_pulse,
    input  logic [3:0]  sw,
    output logic [3:0]  n_out,
    output logic [3:0]  cap_out,
    output logic [31:0] w_out,
    output logic [31:0] p_out,
    output logic        start,
    input  logic        solver_done,
    input  logic        solver_err,
    input  logic [7:0]  solver_sel,
    output logic [31:0] number,
    output logic [7:0]  an_mask
);

    state_e      r_state, w_state_d;
    logic [3:0]  r_n, w_n_d;
    logic [3:0]  r_cap, w_cap_d;
    logic [31:0] r_w, w_w_d;
    logic [31:0] r_p, w_p_d;
    logic [7:0]  r_sel, w_sel_d;
    logic [3:0]  r_code, w_code_d;
    logic [3:0]  r_idx, w_idx_d;
    logic        r_start, w_start_d;
    logic [31:0] r_number, w_number_d;
    logic [7:0]  r_an_mask, w_an_mask_d;
    logic [4:0]  w_bit;
    logic        w_expired;

    // idx is 1..8; the 3-bit wrap of idx-1 maps 8 onto slot 7 correctly
    assign w_bit = {r_idx[2:0] - 3'd1, 2'b00};

    solver_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (r_start),
        .enable (r_state == S_RUN),
        .expired(w_expired)
    );

    // Next-state and problem-register updates; back takes priority over confirm
    always_comb begin
        w_state_d = r_state;
        w_n_d     = r_n;
        w_cap_d   = r_cap;
        w_w_d     = r_w;
        w_p_d     = r_p;
        w_sel_d   = r_sel;
        w_code_d  = r_code;
        w_idx_d   = r_idx;
        w_start_d = 1'b0;
        case (r_state)
            S_N: begin
                if (conf_pulse && !back_pulse) begin
                    if (sw == 4'd0) begin
                        w_state_d = S_ERR;
                        w_code_d  = ERR_ZERO_N;
                    end else if (32'(sw) <= MAX_N) begin
                        w_n_d     = sw;
                        w_state_d = S_CAP;
                    end
                end
            end
            S_CAP: begin
                if (back_pulse) begin
                    w_state_d = S_N;
                end else if (conf_pulse) begin
                    w_cap_d   = sw;
                    w_idx_d   = 4'd1;
                    w_state_d = S_WT;
                end
            end
            S_WT: begin
                if (back_pulse) begin
                    if (r_idx > 4'd1) w_idx_d = r_idx - 4'd1;
                    else              w_state_d = S_CAP;
                end else if (conf_pulse) begin
                    w_w_d[w_bit +: 4] = sw;
                    if (r_idx < r_n) begin
                        w_idx_d = r_idx + 4'd1;
                    end else begin
                        w_idx_d   = 4'd1;
                        w_state_d = S_PR;
                    end
                end
            end
            S_PR: begin
                if (back_pulse) begin
                    if (r_idx > 4'd1) begin
                        w_idx_d = r_idx - 4'd1;
                    end else begin
                        w_idx_d   = r_n;
                        w_state_d = S_WT;
                    end
                end else if (conf_pulse) begin
                    w_p_d[w_bit +: 4] = sw;
                    if (r_idx < r_n) begin
                        w_idx_d = r_idx + 4'd1;
                    end else begin
                        w_state_d = S_RUN;
                        w_start_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (solver_err) begin
                    w_state_d = S_ERR;
                    w_code_d  = ERR_SOLVER;
                end else if (solver_done) begin
                    w_sel_d   = solver_sel;
                    w_state_d = S_SHOW;
                end else if (w_expired) begin
                    w_state_d = S_ERR;
                    w_code_d  = ERR_TIMEOUT;
                end
            end
            S_SHOW, S_ERR: begin
                if (back_pulse) begin
                    w_n_d     = '0;
                    w_cap_d   = '0;
                    w_w_d     = '0;
                    w_p_d     = '0;
                    w_sel_d   = '0;
                    w_code_d  = '0;
                    w_idx_d   = '0;
                    w_state_d = S_N;
                end
            end
            default: w_state_d = S_N;
        endcase
    end

    // Display contents for the state being entered, so they land with the state change
    always_comb begin
        w_number_d  = '0;
        w_an_mask_d = 8'h00;
        case (w_state_d)
            S_N:   w_number_d = {GLYPH_N, GLYPH_N, 20'h0, sw};
            S_CAP: w_number_d = {GLYPH_W, GLYPH_W, 20'h0, sw};
            S_WT:  w_number_d = {w_idx_d, GLYPH_W, 20'h0, sw};
            S_PR:  w_number_d = {w_idx_d, GLYPH_P, 20'h0, sw};
            S_RUN: w_an_mask_d = 8'hFF;
            S_SHOW: begin
                for (int i = 0; i < 8; i++) begin
                    if (i < int'(w_n_d)) w_number_d[4*i +: 4] = {3'b000, w_sel_d[i]};
                end
                w_an_mask_d = 8'hFF << w_n_d;
            end
            S_ERR: begin
                w_number_d  = {24'h0, 4'hE, w_code_d};
                w_an_mask_d = 8'hFC;
            end
            default: w_an_mask_d = 8'hFF;
        endcase
    end

    // State, problem registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_N;
            r_n       <= '0;
            r_cap     <= '0;
            r_w       <= '0;
            r_p       <= '0;
            r_sel     <= '0;
            r_code    <= '0;
            r_idx     <= '0;
            r_start   <= 1'b0;
            r_number  <= {GLYPH_N, GLYPH_N, 20'h0, sw};
            r_an_mask <= 8'h00;
        end else begin
            r_state   <= w_state_d;
            r_n       <= w_n_d;
            r_cap     <= w_cap_d;
            r_w       <= w_w_d;
            r_p       <= w_p_d;
            r_sel     <= w_sel_d;
            r_code    <= w_code_d;
            r_idx     <= w_idx_d;
            r_start   <= w_start_d;
            r_number  <= w_number_d;
            r_an_mask <= w_an_mask_d;
        end
    end

    assign n_out   = r_n;
    assign cap_out = r_cap;
    assign w_out   = r_w;
    assign p_out   = r_p;
    assign start   = r_start;
    assign number  = r_number;
    assign an_mask = r_an_mask;

endmodule

// File: tb/tb_knapsack_seq.sv
// Directed bench for the knapsack sequencer.
module tb_knapsack_seq;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        conf_pulse = 1'b0;
    logic        back_pulse = 1'b0;
    logic [3:0]  sw = 4'h5;
    logic        solver_done = 1'b0;
    logic        solver_err = 1'b0;
    logic [7:0]  solver_sel = 8'h00;
    logic [3:0]  n_out, cap_out;
    logic [31:0] w_out, p_out, number;
    logic        start;
    logic [7:0]  an_mask;

    int n_checks = 0;
    int n_fail = 0;

    knapsack_seq #(
        .MAX_N  (8),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .conf_pulse (conf_pulse),
        .back_pulse (back_pulse),
        .sw         (sw),
        .n_out      (n_out),
        .cap_out    (cap_out),
        .w_out      (w_out),
        .p_out      (p_out),
        .start      (start),
        .solver_done(solver_done),
        .solver_err (solver_err),
        .solver_sel (solver_sel),
        .number     (number),
        .an_mask    (an_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic conf(input logic [3:0] v);
        sw = v;
        conf_pulse = 1'b1;
        tick();
        conf_pulse = 1'b0;
    endtask

    task automatic back(input logic [3:0] v);
        sw = v;
        back_pulse = 1'b1;
        tick();
        back_pulse = 1'b0;
    endtask

    task automatic test_reset();
        sw = 4'h5;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if ({number, an_mask} !== {32'hEE000005, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_display: got %h/%h want EE000005/00", number, an_mask);
        end
        n_checks++;
        if ({n_out, cap_out, w_out, p_out, start} !== 73'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got n=%h cap=%h w=%h p=%h start=%b want all 0",
                     n_out, cap_out, w_out, p_out, start);
        end
        sw = 4'h6;
        tick();
        n_checks++;
        if (number !== 32'hEE000006) begin
            n_fail++;
            $display("FAIL sw_tracking: got %h want EE000006", number);
        end
    endtask

    task automatic test_full_entry();
        conf(4'd3);
        n_checks++;
        if ({number, n_out} !== {32'hBB000003, 4'd3}) begin
            n_fail++;
            $display("FAIL cap_prompt: got %h n=%h want BB000003 n=3", number, n_out);
        end
        conf(4'd7);
        n_checks++;
        if ({number, cap_out} !== {32'h1B000007, 4'd7}) begin
            n_fail++;
            $display("FAIL wt1_prompt: got %h cap=%h want 1B000007 cap=7", number, cap_out);
        end
        conf(4'd2);
        conf(4'd3);
        n_checks++;
        if (number !== 32'h3B000003) begin
            n_fail++;
            $display("FAIL wt3_prompt: got %h want 3B000003", number);
        end
        conf(4'd4);
        n_checks++;
        if ({number, w_out} !== {32'h1C000004, 32'h00000432}) begin
            n_fail++;
            $display("FAIL pr1_prompt: got %h w=%h want 1C000004 w=00000432", number, w_out);
        end
        conf(4'd5);
        conf(4'd6);
        n_checks++;
        if ({number, start} !== {32'h3C000006, 1'b0}) begin
            n_fail++;
            $display("FAIL pr3_prompt: got %h start=%b want 3C000006 start=0", number, start);
        end
        conf(4'd1);
        n_checks++;
        if ({start, number, an_mask, p_out} !== {1'b1, 32'h0, 8'hFF, 32'h00000165}) begin
            n_fail++;
            $display("FAIL run_entry: got start=%b %h/%h p=%h want 1 00000000/FF p=00000165",
                     start, number, an_mask, p_out);
        end
        tick();
        n_checks++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL start_one_cycle: got start=%b want 0", start);
        end
        solver_done = 1'b1;
        solver_sel = 8'b0000_0101;
        tick();
        solver_done = 1'b0;
        solver_sel = 8'h00;
        n_checks++;
        if ({number, an_mask} !== {32'h00000101, 8'hF8}) begin
            n_fail++;
            $display("FAIL show_result: got %h/%h want 00000101/F8", number, an_mask);
        end
        conf(4'd2);
        n_checks++;
        if ({number, an_mask} !== {32'h00000101, 8'hF8}) begin
            n_fail++;
            $display("FAIL show_ignores_conf: got %h/%h want 00000101/F8", number, an_mask);
        end
        back(4'h9);
        n_checks++;
        if ({number, an_mask, n_out, w_out, p_out} !==
            {32'hEE000009, 8'h00, 4'h0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL show_back_clear: got %h/%h n=%h w=%h p=%h want EE000009/00 zeros",
                     number, an_mask, n_out, w_out, p_out);
        end
    endtask

    task automatic test_zero_n();
        conf(4'd0);
        n_checks++;
        if ({number, an_mask} !== {32'h000000E1, 8'hFC}) begin
            n_fail++;
            $display("FAIL zero_n_err: got %h/%h want 000000E1/FC", number, an_mask);
        end
        back(4'hA);
        n_checks++;
        if ({number, an_mask} !== {32'hEE00000A, 8'h00}) begin
            n_fail++;
            $display("FAIL zero_n_back: got %h/%h want EE00000A/00", number, an_mask);
        end
    endtask

    task automatic test_n_over_max();
        conf(4'd9);
        n_checks++;
        if ({number, n_out} !== {32'hEE000009, 4'd0}) begin
            n_fail++;
            $display("FAIL n9_ignored: got %h n=%h want EE000009 n=0", number, n_out);
        end
        conf(4'd2);
        n_checks++;
        if ({number, n_out} !== {32'hBB000002, 4'd2}) begin
            n_fail++;
            $display("FAIL n2_accepted: got %h n=%h want BB000002 n=2", number, n_out);
        end
    endtask

    // Continues from the capacity prompt with N = 2
    task automatic test_back_navigation();
        conf(4'd5);
        conf(4'd7);
        conf(4'd8);
        n_checks++;
        if ({number, w_out} !== {32'h1C000008, 32'h00000087}) begin
            n_fail++;
            $display("FAIL wt_done: got %h w=%h want 1C000008 w=00000087", number, w_out);
        end
        back(4'd0);
        n_checks++;
        if (number !== 32'h2B000000) begin
            n_fail++;
            $display("FAIL pr_back_to_wt: got %h want 2B000000", number);
        end
        back(4'd0);
        n_checks++;
        if (number !== 32'h1B000000) begin
            n_fail++;
            $display("FAIL wt_back_idx: got %h want 1B000000", number);
        end
        back(4'd0);
        n_checks++;
        if ({number, cap_out} !== {32'hBB000000, 4'd5}) begin
            n_fail++;
            $display("FAIL wt_back_cap: got %h cap=%h want BB000000 cap=5", number, cap_out);
        end
        conf(4'd5);
        conf(4'd9);
        n_checks++;
        if ({number, w_out} !== {32'h2B000009, 32'h00000089}) begin
            n_fail++;
            $display("FAIL reconfirm_nib0: got %h w=%h want 2B000009 w=00000089", number, w_out);
        end
        conf(4'd8);
    endtask

    // Starts in the price prompt at idx 1 with N = 2
    task automatic test_conf_back_same_cycle();
        sw = 4'd3;
        conf_pulse = 1'b1;
        back_pulse = 1'b1;
        tick();
        conf_pulse = 1'b0;
        back_pulse = 1'b0;
        n_checks++;
        if ({number, p_out} !== {32'h2B000003, 32'h0}) begin
            n_fail++;
            $display("FAIL back_beats_conf: got %h p=%h want 2B000003 p=0", number, p_out);
        end
        conf(4'd8);
    endtask

    task automatic test_timeout();
        conf(4'd1);
        conf(4'd2);
        n_checks++;
        if ({start, p_out} !== {1'b1, 32'h00000021}) begin
            n_fail++;
            $display("FAIL timeout_start: got start=%b p=%h want 1 p=00000021", start, p_out);
        end
        repeat (TO) tick();
        n_checks++;
        if ({number, an_mask} !== {32'h0, 8'hFF}) begin
            n_fail++;
            $display("FAIL before_timeout: got %h/%h want 00000000/FF", number, an_mask);
        end
        tick();
        n_checks++;
        if ({number, an_mask} !== {32'h000000E4, 8'hFC}) begin
            n_fail++;
            $display("FAIL timeout_err: got %h/%h want 000000E4/FC", number, an_mask);
        end
        back(4'd0);
    endtask

    task automatic test_err_priority();
        conf(4'd1);
        conf(4'd3);
        conf(4'd2);
        conf(4'd4);
        solver_err = 1'b1;
        solver_done = 1'b1;
        solver_sel = 8'h01;
        tick();
        solver_err = 1'b0;
        solver_done = 1'b0;
        solver_sel = 8'h00;
        n_checks++;
        if ({number, an_mask} !== {32'h000000E3, 8'hFC}) begin
            n_fail++;
            $display("FAIL err_over_done: got %h/%h want 000000E3/FC", number, an_mask);
        end
        back(4'd0);
    endtask

    task automatic test_reset_mid_run();
        conf(4'd1);
        conf(4'd3);
        conf(4'd2);
        conf(4'd4);
        n_checks++;
        if ({start, w_out, p_out} !== {1'b1, 32'h2, 32'h4}) begin
            n_fail++;
            $display("FAIL mid_run_start: got start=%b w=%h p=%h want 1 2 4", start, w_out, p_out);
        end
        sw = 4'h7;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({start, w_out, p_out, n_out, number} !== {1'b0, 32'h0, 32'h0, 4'h0, 32'hEE000007}) begin
            n_fail++;
            $display("FAIL mid_run_reset: got start=%b w=%h p=%h n=%h %h want 0 0 0 0 EE000007",
                     start, w_out, p_out, n_out, number);
        end
        solver_done = 1'b1;
        solver_sel = 8'hFF;
        tick();
        solver_done = 1'b0;
        solver_sel = 8'h00;
        n_checks++;
        if ({number, an_mask} !== {32'hEE000007, 8'h00}) begin
            n_fail++;
            $display("FAIL late_done_ignored: got %h/%h want EE000007/00", number, an_mask);
        end
    endtask

    initial begin
        test_reset();
        test_full_entry();
        test_zero_n();
        test_n_over_max();
        test_back_navigation();
        test_conf_back_same_cycle();
        test_timeout();
        test_err_priority();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
